uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop line synchronizer, mid-bit sampling frame FSM and a
// held output word with parity/framing/overrun status under a char_ack handshake.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] char,
  output logic                 newChar,
  input  logic                 char_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS + 2) + 1;

  localparam logic [TW-1:0] HALF_M1    = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_M1     = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_M1    = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_M1    = BW'(STOP_BITS - 1);
  localparam logic          ODD_MODE   = (PARITY == 1);
  localparam logic          HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic                 rx_meta, rx_s, rx_prev;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad, frm_bad, done_q;

  logic fall, half_tick, bit_tick, ack_take;
  logic timer_clr, cnt_clr, frame_clr;
  logic take_data, take_par, take_stop, done;

  // ---------------------------------------------------------------------------
  // Line synchronizer. Flops reset to the idle level so reset release never
  // looks like a start edge. rx_prev keeps following the line in every state,
  // so a line held low after a bad stop bit cannot produce a new start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each flop see the previous value of
      // the one before it; blocking here would collapse the chain into one flop.
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall      = rx_prev & ~rx_s;
  assign half_tick = (timer == HALF_M1);
  assign bit_tick  = (timer == BIT_M1);
  assign ack_take  = char_ack & newChar;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_next = state;
    timer_clr  = 1'b0;
    cnt_clr    = 1'b0;
    frame_clr  = 1'b0;
    take_data  = 1'b0;
    take_par   = 1'b0;
    take_stop  = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        timer_clr = 1'b1;
        cnt_clr   = 1'b1;
        frame_clr = 1'b1;
        if (fall) state_next = S_START;
      end

      // Half a bit in: a line back high was a glitch; otherwise re-centre the
      // timer so every later sample lands mid-bit.
      S_START: begin
        if (half_tick) begin
          timer_clr  = 1'b1;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          take_data = 1'b1;
          if (bit_cnt == DATA_M1) begin
            cnt_clr    = 1'b1;
            state_next = HAS_PARITY ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          timer_clr  = 1'b1;
          take_par   = 1'b1;
          state_next = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          take_stop = 1'b1;
          if (bit_cnt == STOP_M1) begin
            done       = 1'b1;
            state_next = S_IDLE;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit timer, sample counter, shift register and per-frame error capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
      frm_bad <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      timer <= timer_clr ? '0 : timer + TW'(1);

      if (cnt_clr)                    bit_cnt <= '0;
      else if (take_data | take_stop) bit_cnt <= bit_cnt + BW'(1);

      // Right shift: after DATA_BITS samples the first bit sits in bit 0.
      if (take_data) shift <= {rx_s, shift[DATA_BITS-1:1]};

      if (frame_clr)     par_bad <= 1'b0;
      else if (take_par) par_bad <= ((^shift) ^ rx_s) != ODD_MODE;

      if (frame_clr)              frm_bad <= 1'b0;
      else if (take_stop && !rx_s) frm_bad <= 1'b1;

      done_q <= done;
    end
  end

  // ---------------------------------------------------------------------------
  // Output word and status. A completion always wins over an acknowledge: the
  // new word replaces the old one, and overrun records only a word dropped
  // without being acknowledged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char       <= '0;
      newChar    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_q) begin
      char       <= shift;
      parity_err <= par_bad;
      frame_err  <= frm_bad;
      newChar    <= 1'b1;
      overrun    <= ack_take ? 1'b0 : (overrun | newChar);
    end else if (ack_take) begin
      newChar    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: two instances (defaults, and even parity with two
// stop bits) driven by a serial line model; a monitor pops expected words per delivery.
module tb_uart_rx_core;

  localparam int DB    = 8;
  localparam int CPB_A = 16;
  localparam int PAR_A = 0;
  localparam int SB_A  = 1;
  localparam int CPB_B = 8;
  localparam int PAR_B = 2;
  localparam int SB_B  = 2;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       ovr;
    int         t_fall;
  } exp_t;

  logic          clk, rst_n;
  logic          rx_a, rx_b, ack_a, ack_b;
  logic [DB-1:0] char_a, char_b;
  logic          nc_a, nc_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  bit         auto_ack[2];
  int         ack_req[2];
  int         ack_done[2];
  bit         pend[2];
  logic       prev_nc[2];
  logic       prev_ov[2];
  logic [7:0] prev_ch[2];

  uart_rx_core #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB), .PARITY(PAR_A), .STOP_BITS(SB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .UART_RX(rx_a), .char(char_a), .newChar(nc_a),
    .char_ack(ack_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a)
  );

  uart_rx_core #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB), .PARITY(PAR_B), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .UART_RX(rx_b), .char(char_b), .newChar(nc_b),
    .char_ack(ack_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference rules
  // ---------------------------------------------------------------------------
  function automatic int cpb_of(input int inst);
    return (inst == 0) ? CPB_A : CPB_B;
  endfunction

  function automatic int par_of(input int inst);
    return (inst == 0) ? PAR_A : PAR_B;
  endfunction

  function automatic int sb_of(input int inst);
    return (inst == 0) ? SB_A : SB_B;
  endfunction

  // Fall-to-newChar latency: (bits in frame - 0.5) bit periods + 3 cycles.
  function automatic int lat_of(input int inst);
    int nbits;
    nbits = 1 + DB + ((par_of(inst) != 0) ? 1 : 0) + sb_of(inst);
    return ((2 * nbits - 1) * cpb_of(inst)) / 2 + 3;
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_pbit(input int mode, input logic [7:0] d);
    if (mode == 1) return ($countones(d) % 2) == 0;
    return ($countones(d) % 2) == 1;
  endfunction

  function automatic logic exp_pe(input int mode, input logic [7:0] d, input logic pbit);
    int ones;
    if (mode == 0) return 1'b0;
    ones = $countones(d) + (pbit ? 1 : 0);
    return (mode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) rx_a = v;
    else           rx_b = v;
  endtask

  task automatic set_ack(input int inst, input logic v);
    if (inst == 0) ack_a = v;
    else           ack_b = v;
  endtask

  task automatic wait_bits(input int inst, input int n);
    repeat (n * cpb_of(inst)) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one step per instance per falling clock edge
  // ---------------------------------------------------------------------------
  task automatic mon_step(input int inst, input logic [7:0] ch, input logic nc,
                          input logic pe, input logic fe, input logic ov);
    exp_t e;
    bit   have;
    bit   delivered;
    if (rst_n !== 1'b1) begin
      pend[inst] = 1'b0;
      set_ack(inst, 1'b0);
    end else if (pend[inst]) begin
      check($sformatf("ack%0d_clears_newChar", inst), nc, 1'b0);
      check($sformatf("ack%0d_clears_overrun", inst), ov, 1'b0);
      check($sformatf("ack%0d_clears_flags", inst), {pe, fe}, 2'b00);
      pend[inst] = 1'b0;
      set_ack(inst, 1'b0);
    end else begin
      delivered = (nc === 1'b1) &&
                  (prev_nc[inst] !== 1'b1 || ch !== prev_ch[inst] || ov !== prev_ov[inst]);
      if (delivered) begin
        have = (inst == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        check($sformatf("inst%0d_delivery_expected", inst), have, 1'b1);
        if (have) begin
          e = (inst == 0) ? q_a.pop_front() : q_b.pop_front();
          check($sformatf("inst%0d_char", inst), ch, e.data);
          check($sformatf("inst%0d_parity_err", inst), pe, e.pe);
          check($sformatf("inst%0d_frame_err", inst), fe, e.fe);
          check($sformatf("inst%0d_overrun", inst), ov, e.ovr);
          check_near($sformatf("inst%0d_latency", inst), cyc - e.t_fall, lat_of(inst), 1);
        end
        if (auto_ack[inst]) begin
          set_ack(inst, 1'b1);
          pend[inst] = 1'b1;
        end
      end else if (nc === 1'b1 && ack_req[inst] > ack_done[inst]) begin
        set_ack(inst, 1'b1);
        pend[inst] = 1'b1;
        ack_done[inst]++;
      end
    end
    prev_nc[inst] = nc;
    prev_ch[inst] = ch;
    prev_ov[inst] = ov;
  endtask

  initial begin
    ack_a = 1'b0;
    ack_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i]     = 1'b0;
      ack_done[i] = 0;
      prev_nc[i]  = 1'b0;
      prev_ov[i]  = 1'b0;
      prev_ch[i]  = 8'h00;
    end
    forever begin
      @(negedge clk);
      mon_step(0, char_a, nc_a, pe_a, fe_a, ov_a);
      mon_step(1, char_b, nc_b, pe_b, fe_b, ov_b);
    end
  end

  // ---------------------------------------------------------------------------
  // Line driver: start bit, data LSB first, optional parity, stop bits, then an
  // optional extra low hold (break) before the line returns to idle.
  // ---------------------------------------------------------------------------
  task automatic send_frame(input int inst, input logic [7:0] data, input logic par_flip,
                            input logic [1:0] stops, input int hold_low,
                            input logic ovr, input bit exp_en);
    int   pm, ns;
    logic pbit;
    logic bq[$];
    exp_t e;
    pm   = par_of(inst);
    ns   = sb_of(inst);
    pbit = good_pbit(pm, data) ^ par_flip;
    bq.push_back(1'b0);
    for (int k = 0; k < DB; k++) bq.push_back(data[k]);
    if (pm != 0) bq.push_back(pbit);
    for (int s = 0; s < ns; s++) bq.push_back(stops[s]);
    e.data = data;
    e.pe   = exp_pe(pm, data, pbit);
    e.fe   = (ns == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
    e.ovr  = ovr;
    @(negedge clk);
    e.t_fall = cyc;
    if (exp_en) begin
      if (inst == 0) q_a.push_back(e);
      else           q_b.push_back(e);
    end
    foreach (bq[k]) begin
      set_line(inst, bq[k]);
      repeat (cpb_of(inst)) @(negedge clk);
    end
    repeat (hold_low * cpb_of(inst)) @(negedge clk);
    set_line(inst, 1'b1);
  endtask

  task automatic random_frames(input int inst, input int count);
    logic [7:0] d;
    logic       flip, err;
    logic [1:0] st;
    int         gap;
    for (int n = 0; n < count; n++) begin
      d    = 8'($urandom_range(0, 255));
      flip = (par_of(inst) != 0) && ($urandom_range(0, 3) == 0);
      err  = ($urandom_range(0, 5) == 0);
      st   = err ? 2'($urandom_range(0, 2)) : 2'b11;
      if (sb_of(inst) == 1 && err) st = 2'b10;
      gap  = $urandom_range(0, 2) + (err ? 1 : 0);
      send_frame(inst, d, flip, st, 0, 1'b0, 1'b1);
      wait_bits(inst, gap);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] partial;
    rst_n       = 1'b0;
    rx_a        = 1'b1;
    rx_b        = 1'b1;
    auto_ack[0] = 1'b1;
    auto_ack[1] = 1'b1;
    ack_req[0]  = 0;
    ack_req[1]  = 0;

    repeat (4) @(negedge clk);
    check("rst_char_a", char_a, 8'h00);
    check("rst_newChar_a", nc_a, 1'b0);
    check("rst_flags_a", {pe_a, fe_a, ov_a}, 3'b000);
    check("rst_char_b", char_b, 8'h00);
    check("rst_newChar_b", nc_b, 1'b0);
    check("rst_flags_b", {pe_b, fe_b, ov_b}, 3'b000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain frame, left unacknowledged: newChar must hold.
    auto_ack[0] = 1'b0;
    send_frame(0, 8'h5A, 1'b0, 2'b11, 0, 1'b0, 1'b1);
    wait_bits(0, 2);
    check("q_a_drained_5a", q_a.size(), 0);
    check("newChar_held_5a", nc_a, 1'b1);
    ack_req[0]++;
    repeat (4) @(negedge clk);
    auto_ack[0] = 1'b1;

    // Even parity: 0x07 with a wrong then a right parity bit.
    send_frame(1, 8'h07, 1'b1, 2'b11, 0, 1'b0, 1'b1);
    send_frame(1, 8'h07, 1'b0, 2'b11, 0, 1'b0, 1'b1);
    wait_bits(1, 2);
    check("q_b_drained_parity", q_b.size(), 0);

    // Short glitch must be rejected; the next frame must still be received.
    @(negedge clk);
    set_line(0, 1'b0);
    repeat (CPB_A / 4) @(negedge clk);
    set_line(0, 1'b1);
    wait_bits(0, 3);
    send_frame(0, 8'h3C, 1'b0, 2'b11, 0, 1'b0, 1'b1);
    wait_bits(0, 2);
    check("q_a_drained_glitch", q_a.size(), 0);

    // Break: 0xFF with stop low and the line held low 3 bit times in total.
    send_frame(0, 8'hFF, 1'b0, 2'b00, 2, 1'b0, 1'b1);
    wait_bits(0, 4);
    send_frame(0, 8'h81, 1'b0, 2'b11, 0, 1'b0, 1'b1);
    wait_bits(0, 2);
    check("q_a_drained_break", q_a.size(), 0);

    // Back-to-back without acknowledge: second word overwrites, overrun set.
    auto_ack[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11, 0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 2'b11, 0, 1'b1, 1'b1);
    wait_bits(0, 2);
    check("q_a_drained_overrun", q_a.size(), 0);
    check("overrun_held", ov_a, 1'b1);
    ack_req[0]++;
    repeat (4) @(negedge clk);

    // Reset in the middle of data bit 4 of 0xA5 with an unconsumed word held.
    send_frame(0, 8'h66, 1'b0, 2'b11, 0, 1'b0, 1'b1);
    wait_bits(0, 2);
    check("q_a_drained_66", q_a.size(), 0);
    partial = 8'hA5;
    @(negedge clk);
    set_line(0, 1'b0);
    repeat (CPB_A) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      set_line(0, partial[k]);
      repeat ((k == 4) ? CPB_A / 2 : CPB_A) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_char", char_a, 8'h00);
    check("midrst_newChar", nc_a, 1'b0);
    check("midrst_flags", {pe_a, fe_a, ov_a}, 3'b000);
    set_line(0, 1'b1);
    rst_n = 1'b1;
    wait_bits(0, 12);
    auto_ack[0] = 1'b1;
    send_frame(0, 8'hA5, 1'b0, 2'b11, 0, 1'b0, 1'b1);
    wait_bits(0, 2);
    check("q_a_drained_a5", q_a.size(), 0);

    // Randomized traffic on both instances in parallel.
    fork
      random_frames(0, 16);
      random_frames(1, 24);
    join
    wait_bits(0, 3);

    check("q_a_final_drained", q_a.size(), 0);
    check("q_b_final_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
